button_conditioner: RTL
=======================

// Module: button_conditioner
// PURPOSE
//   Input-side front end for the 7-segment counter chip: turns raw push-button levels into clean control signals for the counter state machine.
//   Each of start/progressive/regressive is synchronised, debounced and edge-detected.
//   Start becomes a 1-cycle pulse. Progressive/regressive presses set a latched, mutually exclusive direction mode, which finish clears.
// PARAMETERS
//   DEBOUNCE_CYCLES  1_000_000  consecutive stable cycles required before a level change is accepted (10 ms @ 100 MHz); min 2
//   CNT_W            20         debounce counter width; must satisfy 2**CNT_W > DEBOUNCE_CYCLES
// PORTS
//   clk_100MHz     in   1  system clock, all state on rising edge
//   reset_n        in   1  asynchronous, active-low reset
//   btn_start      in   1  raw start button, asynchronous to clk
//   btn_prog       in   1  raw progressive button, asynchronous to clk
//   btn_reg        in   1  raw regressive button, asynchronous to clk
//   finish         in   1  counter reached its end value, synchronous level
//   start          out  1  one-cycle pulse per accepted start press
//   progressive    out  1  level: direction mode = PROG
//   regressive     out  1  level: direction mode = REG
//   btn_level      out  3  debounced levels {reg,prog,start}, for debug/LEDs
// BEHAVIOUR
//   Reset (reset_n=0, async): sync flops, stable levels, counters = 0; start=0, progressive=0, regressive=0, btn_level=3'b000, mode=IDLE.
//   Reset released mid-bounce: channel restarts from stable=0. Nothing is emitted for a button already held at reset until it is seen
//   stable high for DEBOUNCE_CYCLES; then it yields one press.
//   Per channel (3 identical instances):
//   - 2-flop synchroniser: sync2 lags the raw input by 2 edges.
//   - Counter cnt:
//       cleared whenever sync2 == stable;
//       otherwise incremented;
//       when cnt == DEBOUNCE_CYCLES-1 and sync2 != stable: stable <= sync2, cnt <= 0.
//   - Any glitch shorter than DEBOUNCE_CYCLES cycles is discarded entirely. Counter never wraps.
//   - press pulse = 1 in exactly the first cycle stable is 1 (registered, stable rose on the previous edge); releases produce no pulse.
//   - Latency: raw rise held steady before edge 0 -> press pulse high after edge 2+DEBOUNCE_CYCLES, for one cycle.
//   start = start-channel press pulse. It is not gated by mode; the downstream FSM decides validity.
//   Mode FSM, states IDLE/PROG/REG (2-bit, registered); priority per edge:
//     1. finish=1              -> IDLE (overrides same-cycle presses)
//     2. prog & reg pulses together -> hold current state (conflict ignored)
//     3. prog pulse            -> PROG (from any state)
//     4. reg pulse             -> REG  (from any state)
//     5. else                  -> hold
//   Outputs decoded from state registers:
//     progressive = (state==PROG), regressive = (state==REG); never both 1.
//   Holding a button never repeats a pulse; re-press needs a debounced release then a debounced press.
// TESTING (bench uses DEBOUNCE_CYCLES=4)
//   1. Reset: reset_n=0 with random buttons -> all outputs 0 immediately (before next clk edge); stay 0 for 6 cycles after release if buttons=0.
//   2. Clean press: btn_start 0->1 held 20 cycles -> start high exactly 1 cycle, 6 edges after change; btn_level[0]=1 same cycle; no further start.
//   3. Bounce: btn_prog toggles every 2 cycles x5, then held 1 -> exactly one pulse, 6 cycles after final rise; progressive=1, regressive=0.
//   4. Mode switch: after test 3, debounced btn_reg press -> regressive=1, progressive=0 in the same cycle.
//   5. Conflict & finish:
//      a) prog and reg rise on the same edge -> mode unchanged.
//      b) finish=1 coincident with a prog pulse -> IDLE, both outputs 0.
//   6. Async reset mid-debounce: reset_n low at cnt=2 -> counters clear, no pulse after release until a full 4-cycle stable window.

Source files
------------

// File: rtl/button_conditioner.sv
// Push-button front end: per-button synchroniser, debouncer and press detector,
// plus a latched, mutually exclusive progressive/regressive direction mode.

module button_debounce_channel #(
    parameter int DEBOUNCE_CYCLES = 1_000_000,
    parameter int CNT_W           = 20
) (
    input  logic clk_i,
    input  logic rst_n_i,
    input  logic raw_i,
    output logic level_o,
    output logic press_o
);

    logic             sync1_q, sync2_q;
    logic             stable_q, stable_d;
    logic             stable_dly_q;
    logic             press_q, press_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;

    // NOTE: sync1_q may go metastable; only sync2_q is ever consumed by logic.
    always_ff @(posedge clk_i or negedge rst_n_i) begin
        if (!rst_n_i) begin
            sync1_q      <= 1'b0;
            sync2_q      <= 1'b0;
            stable_q     <= 1'b0;
            stable_dly_q <= 1'b0;
            press_q      <= 1'b0;
            cnt_q        <= '0;
        end else begin
            sync1_q      <= raw_i;
            sync2_q      <= sync1_q;
            stable_q     <= stable_d;
            stable_dly_q <= stable_q;
            press_q      <= press_d;
            cnt_q        <= cnt_d;
        end
    end

    // NOTE: every always_comb output gets a default first so no latch is inferred.
    always_comb begin
        stable_d = stable_q;
        cnt_d    = '0;
        press_d  = stable_q & ~stable_dly_q;
        if (sync2_q != stable_q) begin
            if (cnt_q == CNT_W'(DEBOUNCE_CYCLES - 1)) begin
                stable_d = sync2_q;
            end else begin
                cnt_d = cnt_q + CNT_W'(1);
            end
        end
    end

    assign level_o = stable_q;
    assign press_o = press_q;

endmodule

module button_conditioner #(
    parameter int DEBOUNCE_CYCLES = 1_000_000,
    parameter int CNT_W           = 20
) (
    input  logic       clk_100MHz,
    input  logic       reset_n,
    input  logic       btn_start,
    input  logic       btn_prog,
    input  logic       btn_reg,
    input  logic       finish,
    output logic       start,
    output logic       progressive,
    output logic       regressive,
    output logic [2:0] btn_level
);

    typedef enum logic [1:0] {
        MODE_IDLE = 2'd0,
        MODE_PROG = 2'd1,
        MODE_REG  = 2'd2
    } mode_e;

    logic [2:0] raw;
    logic [2:0] press;
    mode_e      state_q, state_d;

    assign raw = {btn_reg, btn_prog, btn_start};

    for (genvar ch = 0; ch < 3; ch++) begin : g_chan
        button_debounce_channel #(
            .DEBOUNCE_CYCLES (DEBOUNCE_CYCLES),
            .CNT_W           (CNT_W)
        ) u_chan (
            .clk_i   (clk_100MHz),
            .rst_n_i (reset_n),
            .raw_i   (raw[ch]),
            .level_o (btn_level[ch]),
            .press_o (press[ch])
        );
    end

    always_ff @(posedge clk_100MHz or negedge reset_n) begin
        if (!reset_n) begin
            state_q <= MODE_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // finish dominates; simultaneous prog/reg presses are treated as a conflict and ignored.
    always_comb begin
        state_d = state_q;
        if (finish) begin
            state_d = MODE_IDLE;
        end else if (press[1] && press[2]) begin
            state_d = state_q;
        end else if (press[1]) begin
            state_d = MODE_PROG;
        end else if (press[2]) begin
            state_d = MODE_REG;
        end
    end

    assign start       = press[0];
    assign progressive = (state_q == MODE_PROG);
    assign regressive  = (state_q == MODE_REG);

endmodule
